// File: rtl/clk_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module : clk_mon_pkg
// Brief  : State encoding and saturating arithmetic shared by the clock monitor.
// Rev    : 1.0  initial release
// ============================================================================
package clk_mon_pkg;

    localparam int unsigned c_st_w = 3;

    localparam logic [c_st_w-1:0] c_st_idle   = 3'd0;
    localparam logic [c_st_w-1:0] c_st_arm    = 3'd1;
    localparam logic [c_st_w-1:0] c_st_meas   = 3'd2;
    localparam logic [c_st_w-1:0] c_st_locked = 3'd3;
    localparam logic [c_st_w-1:0] c_st_stall  = 3'd4;

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_mon_sync.sv
`default_nettype none
// ============================================================================
// Module : clk_mon_sync
// Brief  : Sampling flop chain for the divided clock plus registered rise detect.
// Rev    : 1.0  initial release
// ============================================================================
module clk_mon_sync #(
    parameter int SYNC_STAGES = 1
) (
    input  logic clk,
    input  logic rst_h,
    input  logic clk_div_in,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   r_rise;

    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync[0] <= clk_div_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_s_d  <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_s_d;
        end
    end

    // s is the delayed sample so that it lines up with the registered rise
    assign s    = r_s_d;
    assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/clk_div_monitor.sv
`default_nettype none
// ============================================================================
// Module : clk_div_monitor
// Brief  : Measures period/high time of a divided clock, tracks lock, errors, stall.
// Rev    : 1.0  initial release
// ============================================================================
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int EXP_PERIOD  = 3,
    parameter int LOCK_CNT    = 4,
    parameter int TIMEOUT     = 16,
    parameter int SYNC_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_h,
    input  logic             clk_div_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_vld,
    output logic             locked,
    output logic             err,
    output logic             stall,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [31:0] c_cnt_max    = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [31:0] c_good_max   = 32'd15;
    localparam logic [31:0] c_timeout_m1 = 32'(TIMEOUT - 1);

    logic              w_s;
    logic              w_rise;
    logic [c_st_w-1:0] r_state;
    logic [c_st_w-1:0] w_next;
    logic [CNT_W-1:0]  r_per_cnt;
    logic [CNT_W-1:0]  r_hi_cnt;
    logic [CNT_W-1:0]  r_period;
    logic [CNT_W-1:0]  r_high_time;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [3:0]        r_good_cnt;
    logic              r_meas_vld;
    logic              r_err;
    logic [CNT_W-1:0]  w_per_inc;
    logic [CNT_W-1:0]  w_hi_inc;
    logic [CNT_W-1:0]  w_err_inc;
    logic [3:0]        w_good_inc;
    logic              w_good;
    logic              w_timeout;
    logic              w_take;
    logic              w_bad;

    clk_mon_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst_h      (rst_h),
        .clk_div_in (clk_div_in),
        .s          (w_s),
        .rise       (w_rise)
    );

    // per_cnt+1 is both the next count and the period just closed by a rise
    assign w_per_inc  = CNT_W'(sat_inc(32'(r_per_cnt), c_cnt_max));
    assign w_hi_inc   = CNT_W'(sat_inc(32'(r_hi_cnt), c_cnt_max));
    assign w_err_inc  = CNT_W'(sat_inc(32'(r_err_cnt), c_cnt_max));
    assign w_good_inc = 4'(sat_inc(32'(r_good_cnt), c_good_max));
    assign w_good     = (w_per_inc == CNT_W'(EXP_PERIOD));
    assign w_timeout  = (32'(r_per_cnt) >= c_timeout_m1);

    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h) begin
            r_state <= c_st_idle;
        end else if (clr) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        w_bad  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_rise) begin
                    w_next = c_st_arm;
                end else if (w_timeout) begin
                    w_next = c_st_stall;
                end
            end
            // good_cnt is already zero in ARM, so the first period counts as one
            c_st_arm, c_st_meas: begin
                if (w_rise) begin
                    w_take = 1'b1;
                    if (w_good) begin
                        w_next = (w_good_inc == 4'(LOCK_CNT)) ? c_st_locked : c_st_meas;
                    end else begin
                        w_bad  = 1'b1;
                        w_next = c_st_meas;
                    end
                end else if (w_timeout) begin
                    w_next = c_st_stall;
                end
            end
            c_st_locked: begin
                if (w_rise) begin
                    w_take = 1'b1;
                    if (!w_good) begin
                        w_bad  = 1'b1;
                        w_next = c_st_meas;
                    end
                end else if (w_timeout) begin
                    w_next = c_st_stall;
                end
            end
            c_st_stall: begin
                if (w_rise) begin
                    w_next = c_st_arm;
                end
            end
            default: begin
                w_next = c_st_idle;
            end
        endcase
    end

    always_comb begin
        locked = (r_state == c_st_locked);
        stall  = (r_state == c_st_stall);
    end

    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h) begin
            r_per_cnt   <= '0;
            r_hi_cnt    <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_err_cnt   <= '0;
            r_good_cnt  <= '0;
            r_meas_vld  <= 1'b0;
            r_err       <= 1'b0;
        end else if (clr) begin
            r_per_cnt   <= '0;
            r_hi_cnt    <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_err_cnt   <= '0;
            r_good_cnt  <= '0;
            r_meas_vld  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_per_cnt  <= w_rise ? '0 : w_per_inc;
            r_hi_cnt   <= w_rise ? CNT_W'(w_s) : (w_s ? w_hi_inc : r_hi_cnt);
            r_meas_vld <= w_take;
            r_err      <= w_bad;
            if (w_take) begin
                r_period    <= w_per_inc;
                r_high_time <= r_hi_cnt;
            end
            if (w_bad) begin
                r_err_cnt <= w_err_inc;
            end
            if (w_take && w_good) begin
                r_good_cnt <= w_good_inc;
            end else if (w_bad || w_next == c_st_arm || w_next == c_st_stall) begin
                r_good_cnt <= '0;
            end
        end
    end

    assign period    = r_period;
    assign high_time = r_high_time;
    assign meas_vld  = r_meas_vld;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
`default_nettype none
// ============================================================================
// Module : tb_clk_div_monitor
// Brief  : Randomized self-checking bench for clk_div_monitor with a period-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_clk_div_monitor;

    localparam int CNT_W       = 8;
    localparam int EXP_PERIOD  = 3;
    localparam int LOCK_CNT    = 4;
    localparam int TIMEOUT     = 16;
    localparam int SYNC_STAGES = 1;
    localparam int LAT         = SYNC_STAGES + 2;

    logic             clk = 1'b0;
    logic             rst_h;
    logic             clk_div_in;
    logic             clr;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_vld;
    logic             locked;
    logic             err;
    logic             stall;
    logic [CNT_W-1:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_rise_t = 0;
    bit hist [0:4095];

    // reference model state, expressed in periods and input-cycle indices
    logic [7:0] m_period, m_high, m_errcnt;
    logic       m_meas, m_err, m_locked, m_stall;
    int         streak, prev_t, last_edge;
    bit         armed, m_rst, clr_q;

    clk_div_monitor #(
        .CNT_W       (CNT_W),
        .EXP_PERIOD  (EXP_PERIOD),
        .LOCK_CNT    (LOCK_CNT),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst_h      (rst_h),
        .clk_div_in (clk_div_in),
        .clr        (clr),
        .period     (period),
        .high_time  (high_time),
        .meas_vld   (meas_vld),
        .locked     (locked),
        .err        (err),
        .stall      (stall),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    function automatic logic [27:0] obs_vec();
        return {period, high_time, meas_vld, locked, err, stall, err_cnt};
    endfunction

    function automatic logic [27:0] exp_vec();
        return {m_period, m_high, m_meas, m_locked, m_err, m_stall, m_errcnt};
    endfunction

    task automatic model_reset();
        m_period = '0; m_high = '0; m_errcnt = '0;
        m_meas = 1'b0; m_err = 1'b0; m_locked = 1'b0; m_stall = 1'b0;
        streak = 0; armed = 1'b0; last_edge = cyc;
    endtask

    // Evaluate the model for clock edge number cyc: a rise driven at input
    // cycle t is seen by the monitor LAT edges later.
    task automatic model_edge();
        int t;
        int per;
        int hi;
        m_meas = 1'b0;
        m_err  = 1'b0;
        if (m_rst || clr_q) begin
            model_reset();
            return;
        end
        t = cyc - LAT;
        if (t >= 1 && hist[t] && !hist[t-1]) begin
            if (m_stall || !armed) begin
                armed   = 1'b1;
                m_stall = 1'b0;
                streak  = 0;
            end else begin
                per = t - prev_t;
                hi  = 0;
                for (int k = prev_t; k < t; k++) hi += int'(hist[k]);
                m_meas   = 1'b1;
                m_period = 8'((per > 255) ? 255 : per);
                m_high   = 8'((hi > 255) ? 255 : hi);
                if (per == EXP_PERIOD) begin
                    streak = (streak < 15) ? streak + 1 : 15;
                    if (streak >= LOCK_CNT) m_locked = 1'b1;
                end else begin
                    m_err = 1'b1;
                    if (m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
                    streak   = 0;
                    m_locked = 1'b0;
                end
            end
            prev_t    = t;
            last_edge = cyc;
        end else if (!m_stall && (cyc - last_edge) >= TIMEOUT) begin
            m_stall  = 1'b1;
            m_locked = 1'b0;
            streak   = 0;
        end
    endtask

    // One clock: wait for the edge, update the model, then drive the next inputs.
    task automatic step(input logic b, input logic c);
        @(posedge clk);
        cyc++;
        #1;
        model_edge();
        clk_div_in = b;
        clr        = c;
        hist[cyc]  = b;
        if (b && !hist[cyc-1]) last_rise_t = cyc;
        clr_q = c;
    endtask

    task automatic drive_period(input int len, input int hi, input string tag);
        for (int i = 0; i < len; i++) begin
            step(i < hi, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL %s cyc=%0d got=%h required=%h", tag, cyc, obs_vec(), exp_vec());
            if (obs_vec() !== exp_vec()) errors++;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (obs_vec() !== 28'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h required=0", obs_vec());
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        rst_h = 1'b0;
        m_rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL dead_input cyc=%0d got=%h required=%h", cyc, obs_vec(), exp_vec());
            end
            if (k == TIMEOUT - 1) begin
                checks++;
                if (stall !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_early k=%0d got=%b required=0", k, stall);
                end
            end
            if (k == TIMEOUT) begin
                checks++;
                if (stall !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_after_reset k=%0d got=%b required=1", k, stall);
                end
            end
        end
    endtask

    task automatic test_div3();
        for (int p = 0; p < 8; p++) drive_period(3, int'($urandom_range(2, 1)), "div3");
        checks++;
        if (locked !== 1'b1 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL div3_lock got locked=%b err_cnt=%0d required locked=1 err_cnt=0", locked, err_cnt);
        end
    endtask

    task automatic test_stall();
        int tgt;
        tgt = last_rise_t + LAT + TIMEOUT;
        for (int k = 0; k < 25; k++) begin
            step(1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got=%h required=%h", cyc, obs_vec(), exp_vec());
            end
            if (cyc == tgt - 1) begin
                checks++;
                if (stall !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_too_early cyc=%0d got=%b required=0", cyc, stall);
                end
            end
            if (cyc == tgt) begin
                checks++;
                if (stall !== 1'b1 || locked !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_timing cyc=%0d got stall=%b locked=%b required 1/0", cyc, stall, locked);
                end
            end
        end
        for (int p = 0; p < 10; p++) drive_period(3, int'($urandom_range(2, 1)), "stall_resume");
        checks++;
        if (locked !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL relock_after_stall got locked=%b stall=%b required 1/0", locked, stall);
        end
    endtask

    task automatic test_stretch();
        drive_period(4, 1, "stretch");
        for (int p = 0; p < 6; p++) drive_period(3, int'($urandom_range(2, 1)), "stretch_relock");
        checks++;
        if (err_cnt !== 8'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL stretch_result got err_cnt=%0d locked=%b required 1/1", err_cnt, locked);
        end
    endtask

    task automatic test_clr_rise();
        for (int p = 0; p < 6; p++) drive_period(3, int'($urandom_range(2, 1)), "clr_pre");
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        checks++;
        if ({period, meas_vld, locked, err, err_cnt} !== 19'd0) begin
            errors++;
            $display("FAIL clr_with_rise got period=%0d vld=%b locked=%b err=%b err_cnt=%0d required all 0",
                     period, meas_vld, locked, err, err_cnt);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL clr_model cyc=%0d got=%h required=%h", cyc, obs_vec(), exp_vec());
        end
        drive_period(2, 0, "clr_tail");
        for (int p = 0; p < 7; p++) drive_period(3, int'($urandom_range(2, 1)), "clr_relock");
        checks++;
        if (err_cnt !== 8'd0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL clr_relock got err_cnt=%0d locked=%b required 0/1", err_cnt, locked);
        end
    endtask

    task automatic test_div4_sat();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        for (int p = 0; p < 262; p++) drive_period(4, int'($urandom_range(3, 1)), "div4");
        drive_period(4, 0, "div4_flush");
        checks++;
        if (err_cnt !== 8'd255 || locked !== 1'b0) begin
            errors++;
            $display("FAIL div4_saturate got err_cnt=%0d locked=%b required 255/0", err_cnt, locked);
        end
    endtask

    task automatic test_async_reset();
        for (int p = 0; p < 8; p++) drive_period(3, int'($urandom_range(2, 1)), "async_pre");
        drive_period(4, 0, "async_gap");
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL async_prelock got locked=%b required 1", locked);
        end
        #2;
        rst_h = 1'b1;
        m_rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs_vec() !== 28'd0) begin
            errors++;
            $display("FAIL async_reset_immediate got=%h required=0", obs_vec());
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_h = 1'b0;
        m_rst = 1'b0;
        for (int p = 0; p < 6; p++) drive_period(3, int'($urandom_range(2, 1)), "async_post");
        checks++;
        if (locked !== 1'b1 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_relock got locked=%b err_cnt=%0d required 1/0", locked, err_cnt);
        end
    endtask

    initial begin
        clk_div_in = 1'b0;
        clr        = 1'b0;
        rst_h      = 1'b0;
        m_rst      = 1'b1;
        clr_q      = 1'b0;
        prev_t     = 0;
        model_reset();
        #1 rst_h = 1'b1;
        test_reset();
        test_div3();
        test_stall();
        test_stretch();
        test_clr_rise();
        test_div4_sat();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
Receive-side checker for divided clocks produced inside the block (e.g. clk_divider_by3 output). Samples a divided clock in the source clock domain and measures period and high time in source-clock cycles. Declares lock after N consecutive in-spec periods and flags period errors and stalls. Used in benches and as a status source for the APB status register block.

Parameters:
CNT_W, 8, width of period/high counters and measurement outputs
EXP_PERIOD, 3, expected period in clk cycles (rising edge to rising edge)
LOCK_CNT, 4, consecutive good periods required to assert locked (1..15)
TIMEOUT, 16, clk cycles without a rising edge before stall (must be > EXP_PERIOD)
SYNC_STAGES, 1, sampling flops on clk_div_in (1 or 2)

Ports:
clk  input  1  source clock; also the measurement clock
rst_h  input  1  asynchronous active-high reset
clk_div_in  input  1  divided clock under test (rising/falling edges may be on either clk edge)
clr  input  1  synchronous clear of lock/error state and counters
period  output  CNT_W  last measured period, clk cycles
high_time  output  CNT_W  clk cycles sampled high in last period
meas_vld  output  1  1-cycle pulse when period/high_time update
locked  output  1  LOCK_CNT consecutive periods == EXP_PERIOD
err  output  1  1-cycle pulse on a period mismatch
stall  output  1  level; no rising edge seen for TIMEOUT cycles
err_cnt  output  CNT_W  saturating mismatch count

Behaviour:
- Reset (rst_h=1, async): all outputs 0, state IDLE, sync flops 0, internal counters 0.
- Sampling: clk_div_in passes SYNC_STAGES flops on posedge clk -> s; s_d = s delayed one cycle. rise = s & ~s_d.
- Counting: per_cnt increments every cycle, saturates at all-ones; hi_cnt increments when s=1, saturates.
- On rise: period <= per_cnt+1 (saturating), high_time <= hi_cnt, meas_vld=1 the next cycle; per_cnt <= 0; hi_cnt <= s. Latency: meas_vld asserts exactly SYNC_STAGES+2 clk after the input's rising edge appears on clk_div_in.
- States: IDLE (no rise yet), ARM (first rise seen, partial period discarded, no meas_vld), MEAS, LOCKED, STALL.
- IDLE -rise-> ARM -rise-> MEAS (first valid measurement).
- MEAS: good period increments good_cnt (4 bits); good_cnt reaching LOCK_CNT -> LOCKED, locked=1. Bad period: err pulse, err_cnt++ (saturating), good_cnt=0, stay MEAS.
- LOCKED: bad period -> err pulse, err_cnt++, locked=0, good_cnt=0, -> MEAS.
- Any state except IDLE: cycles since last rise >= TIMEOUT -> STALL, stall=1, locked=0, good_cnt=0. In IDLE the timeout also counts, so a dead input after reset gives stall.
- STALL: next rise -> ARM, stall=0; the first period after a stall is discarded.
- high_time is reported only; it is not checked (a div3 output gives high_time 1 or 2 depending on sampling phase).
- clr: synchronous, same effect as reset except that sync flops keep running; clr has priority over a simultaneous rise.
- err and meas_vld for the same period assert in the same cycle.
- Mid-operation reset: immediate return to reset values, with no err pulse.

Decomposition:
- Package clk_mon_pkg: state encoding constants (IDLE, ARM, MEAS, LOCKED, STALL) and a saturating-increment function.
- Sub-module clk_mon_sync: SYNC_STAGES flop chain plus edge detect (outputs s, rise). Everything else stays in the top.

Test Plan:
- Drive clk_div_in from clk_divider_by3 (clk period 2, rst_h pulse at t=2..4) -> period=3 on every meas_vld, locked=1 after the 4th good measurement, err_cnt=0.
- Divide-by-4 stimulus with EXP_PERIOD=3 -> err pulse on every measurement, locked stays 0, err_cnt saturates at 255 after 255 periods.
- Hold clk_div_in=0 after lock -> stall=1 exactly TIMEOUT(16) cycles after the last rise, locked=0. Then resume div3 -> first period discarded, locked returns after 4 further good periods.
- Locked, then a single stretched period of 4 -> one err pulse, locked=0, relock after 4 good periods, err_cnt=1.
- Assert rst_h asynchronously mid-period while locked -> all outputs 0 immediately without waiting for a clk edge. After release, no meas_vld until the second rise.
- clr asserted in the same cycle as a rise -> counters 0, state IDLE, no meas_vld, err_cnt=0.
